hc595_rx: RTL
=============

// Module: hc595_rx
// PURPOSE
// - Receive-side model of a 74HC595 chain: samples the shcp/stcp/ds/oe serial lines produced by the
//   seg_595 transmit path and rebuilds the parallel segment/select word the display would see.
// - Used as a loopback checker inside the FPGA and as the far end of a board-to-board 595 link.
// - All serial inputs are asynchronous to sys_clk; decode is oversampled, with no clock taken from shcp.
// PARAMETERS
// - DATA_W   14  bits per frame (shift-register depth); seg width = DATA_W-SEL_W
// - SEL_W    6   digit-select bits, in the LSBs of the frame
// - SYNC_ST  2   synchronizer flops per serial input (legal values 2..3)
// PORTS
// - sys_clk     in   1             system clock; shcp high and low phases each >= 2 sys_clk
// - sys_rst     in   1             reset, asynchronous assert, active-high
// - shcp        in   1             shift clock; ds is captured on its rising edge
// - stcp        in   1             storage clock; the shift register is copied to the latch on its rising edge
// - ds          in   1             serial data; stable >= 2 sys_clk on each side of shcp rise
// - oe          in   1             output enable, active-low
// - par_data    out  DATA_W        latched frame; forced to 0 while oe is high
// - seg         out  DATA_W-SEL_W  par_data[DATA_W-1:SEL_W]
// - sel         out  SEL_W         par_data[SEL_W-1:0]
// - out_en      out  1             registered ~oe (after synchronizer)
// - data_valid  out  1             1-cycle pulse when par_data is updated by stcp
// - frame_err   out  1             1-cycle pulse, coincident with data_valid, when bit_cnt != DATA_W
// BEHAVIOUR
// - Reset: all synchronizers, shift reg, latch, bit_cnt = 0; par_data/seg/sel/out_en/data_valid/frame_err = 0.
// - Input path: SYNC_ST-flop synchronizer per input, plus one extra flop on shcp/stcp for edge detect.
//   A rise is detected when the last sync stage is 1 and the edge flop is 0.
// - Shift: on a detected shcp rise, sreg <= {sreg[DATA_W-2:0], ds_sync}.
//   The first bit of a frame ends in par_data[DATA_W-1].
// - bit_cnt: width clog2(DATA_W+2); +1 per shift; saturates at DATA_W+1 (overrun stays flagged).
// - Latch: on a detected stcp rise, latch <= sreg; data_valid=1 for the next cycle; frame_err=(bit_cnt!=DATA_W);
//   bit_cnt <= 0. The latch is updated even when frame_err is set (matches the real 595).
// - Simultaneous shcp and stcp rise in one cycle: the latch takes sreg before the shift, the shift still
//   occurs, and bit_cnt <= 1.
// - Latency: a pin edge shows at the outputs SYNC_ST+1 sys_clk later (3 cycles at default).
// - oe: par_data/seg/sel = latch & {DATA_W{out_en}}. The latch is retained while oe is high.
//   Shifting and latching continue regardless of oe.
// - stcp with no shcp since the last latch: latch keeps sreg unchanged; frame_err=1 (bit_cnt=0).
// - Reset mid-frame: partial sreg contents are discarded; the next frame starts at bit_cnt=0.
// - Glitch tolerance: an shcp/stcp pulse shorter than 1 sys_clk may be missed. This is not an error and is not flagged.
// CONFIGURATION
// - HC595_RX_SCAN_EN defined:
//   - adds output digit_seg[SEL_W*(DATA_W-SEL_W)-1:0], reset 0.
//   - On data_valid with sel one-hot (exactly one bit set, bit k), slot k <= seg; other slots hold.
//   - sel not one-hot (0 or >1 bits): no slot updates, and a scan_err 1-cycle pulse is output.
//   - Slot k = digit_seg[k*(DATA_W-SEL_W) +: DATA_W-SEL_W]. Slot updates ignore oe (raw latch used).
// - HC595_RX_SCAN_EN undefined: digit_seg and scan_err do not exist; all other behaviour is identical.
// TESTING (sys_clk 50MHz, shcp period 4 sys_clk, defaults)
// - Shift 14'b11000000_000001 MSB-first, stcp, oe=0 -> 3 cycles after stcp: par_data=14'h3001, seg=8'hC0,
//   sel=6'h01, data_valid 1 cycle, frame_err=0.
// - Shift 13 bits then stcp -> data_valid=1 and frame_err=1. Shift 16 bits then stcp -> frame_err=1
//   and par_data=last 14 bits.
// - Latched 14'h3001, raise oe -> par_data=0, out_en=0. Lower oe -> 14'h3001 reappears with no new data_valid.
// - Shift 13 bits, then shcp and stcp rise together with ds=1 -> latch holds the 13-bit value (zero-extended);
//   frame_err=1; the next stcp after 13 more shifts -> frame_err=0.
// - Assert sys_rst after 7 shifts, release, then send a full frame -> correct par_data and frame_err=0.
// - HC595_RX_SCAN_EN: frames with sel=01,02,..,20 and seg=C0,F9,A4,B0,99,92 -> digit_seg=
//   48'h9299B0A4F9C0. Then sel=6'h03 -> scan_err pulses and digit_seg is unchanged.

Source files
------------

// File: rtl/hc595_rx.sv
// Receive-side 74HC595 chain model: oversamples shcp/stcp/ds/oe and rebuilds the latched frame.
// Optional per-digit scan capture (digit_seg, scan_err) is built when HC595_RX_SCAN_EN is defined.
module hc595_rx #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned SYNC_ST = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      shcp,
    input  logic                      stcp,
    input  logic                      ds,
    input  logic                      oe,
    output logic [DATA_W-1:0]         par_data,
    output logic [DATA_W-SEL_W-1:0]   seg,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_en,
    output logic                      data_valid,
`ifdef HC595_RX_SCAN_EN
    output logic [SEL_W*(DATA_W-SEL_W)-1:0] digit_seg,
    output logic                      scan_err,
`endif
    output logic                      frame_err
);

    localparam int unsigned SEG_W = DATA_W - SEL_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DATA_W + 1);

    logic [SYNC_ST-1:0] shcp_sync_q, stcp_sync_q, ds_sync_q, oe_sync_q;
    logic               shcp_edge_q, stcp_edge_q;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic [DATA_W-1:0]  latch_q, latch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_en_q, data_valid_q, frame_err_q;
    logic               shcp_rise, stcp_rise, ds_s;

    assign shcp_rise = shcp_sync_q[SYNC_ST-1] & ~shcp_edge_q;
    assign stcp_rise = stcp_sync_q[SYNC_ST-1] & ~stcp_edge_q;
    assign ds_s      = ds_sync_q[SYNC_ST-1];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shcp_sync_q <= '0;
            stcp_sync_q <= '0;
            ds_sync_q   <= '0;
            oe_sync_q   <= '0;
            shcp_edge_q <= 1'b0;
            stcp_edge_q <= 1'b0;
        end else begin
            shcp_sync_q <= {shcp_sync_q[SYNC_ST-2:0], shcp};
            stcp_sync_q <= {stcp_sync_q[SYNC_ST-2:0], stcp};
            ds_sync_q   <= {ds_sync_q[SYNC_ST-2:0], ds};
            oe_sync_q   <= {oe_sync_q[SYNC_ST-2:0], oe};
            shcp_edge_q <= shcp_sync_q[SYNC_ST-1];
            stcp_edge_q <= stcp_sync_q[SYNC_ST-1];
        end
    end

    // On a coincident shcp/stcp rise the latch takes the pre-shift register, and the
    // new bit starts the next frame.
    always_comb begin
        sreg_d  = sreg_q;
        latch_d = latch_q;
        cnt_d   = cnt_q;
        if (stcp_rise) begin
            latch_d = sreg_q;
            cnt_d   = '0;
        end
        if (shcp_rise) begin
            sreg_d = {sreg_q[DATA_W-2:0], ds_s};
            if (stcp_rise) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sreg_q       <= '0;
            latch_q      <= '0;
            cnt_q        <= '0;
            out_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            latch_q      <= latch_d;
            cnt_q        <= cnt_d;
            out_en_q     <= ~oe_sync_q[SYNC_ST-1];
            data_valid_q <= stcp_rise;
            frame_err_q  <= stcp_rise && (cnt_q != CntFull);
        end
    end

    assign par_data   = latch_q & {DATA_W{out_en_q}};
    assign seg        = par_data[DATA_W-1:SEL_W];
    assign sel        = par_data[SEL_W-1:0];
    assign out_en     = out_en_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

`ifdef HC595_RX_SCAN_EN
    logic [SEL_W*SEG_W-1:0] digit_q, digit_d;
    logic [SEL_W-1:0]       new_sel;
    logic                   sel_onehot;
    logic                   scan_err_q;

    // Decoded from the raw latch value so slot capture ignores oe.
    assign new_sel    = latch_d[SEL_W-1:0];
    assign sel_onehot = (new_sel != '0) && ((new_sel & (new_sel - SEL_W'(1))) == '0);

    always_comb begin
        digit_d = digit_q;
        if (stcp_rise && sel_onehot) begin
            for (int k = 0; k < int'(SEL_W); k++) begin
                if (new_sel[k]) begin
                    digit_d[k*SEG_W +: SEG_W] = latch_d[DATA_W-1:SEL_W];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            digit_q    <= '0;
            scan_err_q <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            scan_err_q <= stcp_rise && !sel_onehot;
        end
    end

    assign digit_seg = digit_q;
    assign scan_err  = scan_err_q;
`endif

endmodule
